// File: rtl/tsn_pkt_dispatch.sv
// tsn_pkt_dispatch: classifies ingress packets (head/header/body words) and
// replicates each packet onto any subset of NUM_OUT egress channels through a
// two-stage word pipeline, with truncation recovery and packet counters.
module tsn_pkt_dispatch #(
    parameter int unsigned NUM_OUT   = 4,
    parameter logic [15:0] PTP_ETYPE = 16'h88f7,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_data_wr,
    input  logic [133:0]        in_data,
    output logic                in_ready,
    output logic [NUM_OUT-1:0]  out_data_wr,
    output logic [133:0]        out_data,
    output logic [NUM_OUT-1:0]  out_data_valid,
    output logic [NUM_OUT-1:0]  out_data_valid_wr,
    input  logic [NUM_OUT-1:0]  out_alf,
    input  logic [47:0]         device_mac,
    input  logic [NUM_OUT-1:0]  cfg_ucast_mask,
    input  logic [NUM_OUT-1:0]  cfg_bcast_mask,
    input  logic [NUM_OUT-1:0]  cfg_ptp_mask,
    input  logic [NUM_OUT-1:0]  cfg_dflt_mask,
    output logic [CNT_W-1:0]    fwd_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int unsigned WORD_W   = 134;
    localparam logic [1:0]  TAG_HEAD = 2'b01;
    localparam logic [1:0]  TAG_TAIL = 2'b10;

    typedef enum logic [1:0] {HUNT, HDR, FWD, DROP} state_t;

    state_t               state_q, state_d;
    logic [NUM_OUT-1:0]   pkt_mask_q, pkt_mask_d;

    // Pipeline stages: S0 newest, S1 oldest. pend marks a head awaiting its
    // header; eop marks the last word of a packet; bad marks a truncated end.
    logic [WORD_W-1:0]    s0_word_q, s0_word_d, s1_word_q, s1_word_d;
    logic                 s0_vld_q, s0_vld_d, s1_vld_q, s1_vld_d;
    logic [NUM_OUT-1:0]   s0_mask_q, s0_mask_d, s1_mask_q, s1_mask_d;
    logic                 s0_eop_q, s0_eop_d, s1_eop_q, s1_eop_d;
    logic                 s0_pend_q, s0_pend_d, s1_pend_q, s1_pend_d;
    logic                 s1_bad_q, s1_bad_d;

    logic [NUM_OUT-1:0]   out_data_wr_q, out_data_wr_d;
    logic [WORD_W-1:0]    out_data_q, out_data_d;
    logic [NUM_OUT-1:0]   out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0]   out_valid_wr_q, out_valid_wr_d;
    logic [CNT_W-1:0]     fwd_cnt_q, fwd_cnt_d;
    logic [CNT_W-1:0]     drop_cnt_q, drop_cnt_d;

    logic                 is_head, is_tail;
    logic [NUM_OUT-1:0]   cls_mask;
    logic                 classify, kill, trunc, drop_inc;
    logic                 in_vld, in_eop, in_pend;
    logic [NUM_OUT-1:0]   in_mask;
    logic [NUM_OUT-1:0]   m0, m1;
    logic                 p0, p1, drain, shift;

    assign is_head  = (in_data[133:132] == TAG_HEAD);
    assign is_tail  = (in_data[133:132] == TAG_TAIL);
    assign in_ready = ~|out_alf;

    assign out_data_wr       = out_data_wr_q;
    assign out_data          = out_data_q;
    assign out_data_valid    = out_valid_q;
    assign out_data_valid_wr = out_valid_wr_q;
    assign fwd_cnt           = fwd_cnt_q;
    assign drop_cnt          = drop_cnt_q;

    // Header classification: ucast > bcast > ptp > default.
    always_comb begin
        cls_mask = cfg_dflt_mask;
        if (in_data[31:16] == PTP_ETYPE) begin
            if (in_data[127:80] == device_mac &&
                (in_data[15:0] == 16'h0301 || in_data[15:0] == 16'h0401)) begin
                cls_mask = cfg_ucast_mask;
            end else if (in_data[127:80] == 48'hffff_ffff_ffff) begin
                cls_mask = cfg_bcast_mask;
            end else begin
                cls_mask = cfg_ptp_mask;
            end
        end
    end

    // Packet FSM: decides what the accepted word becomes in S0 and which events fire.
    always_comb begin
        state_d    = state_q;
        pkt_mask_d = pkt_mask_q;
        classify   = 1'b0;
        kill       = 1'b0;
        trunc      = 1'b0;
        drop_inc   = 1'b0;
        in_vld     = 1'b0;
        in_mask    = '0;
        in_eop     = 1'b0;
        in_pend    = 1'b0;
        if (in_data_wr) begin
            case (state_q)
                HUNT: begin
                    if (is_head) begin
                        in_vld  = 1'b1;
                        in_pend = 1'b1;
                        state_d = HDR;
                    end
                end
                HDR: begin
                    if (is_head) begin
                        kill     = 1'b1;
                        drop_inc = 1'b1;
                        in_vld   = 1'b1;
                        in_pend  = 1'b1;
                    end else begin
                        classify   = 1'b1;
                        pkt_mask_d = cls_mask;
                        in_vld     = 1'b1;
                        in_mask    = cls_mask;
                        in_eop     = is_tail;
                        drop_inc   = (cls_mask == '0);
                        if (is_tail)              state_d = HUNT;
                        else if (cls_mask != '0)  state_d = FWD;
                        else                      state_d = DROP;
                    end
                end
                FWD: begin
                    if (is_head) begin
                        trunc    = 1'b1;
                        drop_inc = 1'b1;
                        in_vld   = 1'b1;
                        in_pend  = 1'b1;
                        state_d  = HDR;
                    end else begin
                        in_vld  = 1'b1;
                        in_mask = pkt_mask_q;
                        in_eop  = is_tail;
                        if (is_tail) state_d = HUNT;
                    end
                end
                DROP: begin
                    if (is_head) begin
                        in_vld  = 1'b1;
                        in_pend = 1'b1;
                        state_d = HDR;
                    end else if (is_tail) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Pipeline shift, egress strobes and counters.
    always_comb begin
        m0    = (classify && s0_pend_q) ? cls_mask : s0_mask_q;
        m1    = (classify && s1_pend_q) ? cls_mask : s1_mask_q;
        p0    = s0_pend_q && !classify && !kill;
        p1    = s1_pend_q && !classify && !kill;
        drain = (s0_vld_q && s0_eop_q) || (s1_vld_q && s1_eop_q);
        shift = in_data_wr || drain;

        s0_word_d = s0_word_q;  s0_vld_d = s0_vld_q;  s0_mask_d = m0;
        s0_eop_d  = s0_eop_q;   s0_pend_d = p0;
        s1_word_d = s1_word_q;  s1_vld_d = s1_vld_q;  s1_mask_d = m1;
        s1_eop_d  = s1_eop_q;   s1_pend_d = p1;       s1_bad_d  = s1_bad_q;

        out_data_d     = out_data_q;
        out_data_wr_d  = '0;
        out_valid_d    = '0;
        out_valid_wr_d = '0;
        fwd_cnt_d      = fwd_cnt_q;
        drop_cnt_d     = drop_cnt_q;

        if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);

        if (shift) begin
            s1_word_d = s0_word_q;
            s1_vld_d  = s0_vld_q;
            s1_mask_d = m0;
            s1_eop_d  = s0_eop_q || (trunc && s0_vld_q);
            s1_bad_d  = trunc && s0_vld_q;
            s1_pend_d = p0;
            s0_word_d = in_data;
            s0_vld_d  = in_vld;
            s0_mask_d = in_mask;
            s0_eop_d  = in_eop;
            s0_pend_d = in_pend;
            if (s1_vld_q) begin
                out_data_wr_d = m1;
                if (m1 != '0) out_data_d = s1_word_q;
                if (s1_eop_q) begin
                    out_valid_wr_d = m1;
                    out_valid_d    = s1_bad_q ? '0 : m1;
                    if (m1 != '0 && !s1_bad_q) fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            pkt_mask_q     <= '0;
            s0_word_q      <= '0;  s0_vld_q <= 1'b0;  s0_mask_q <= '0;
            s0_eop_q       <= 1'b0; s0_pend_q <= 1'b0;
            s1_word_q      <= '0;  s1_vld_q <= 1'b0;  s1_mask_q <= '0;
            s1_eop_q       <= 1'b0; s1_pend_q <= 1'b0; s1_bad_q <= 1'b0;
            out_data_q     <= '0;
            out_data_wr_q  <= '0;
            out_valid_q    <= '0;
            out_valid_wr_q <= '0;
            fwd_cnt_q      <= '0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            pkt_mask_q     <= pkt_mask_d;
            s0_word_q      <= s0_word_d; s0_vld_q <= s0_vld_d; s0_mask_q <= s0_mask_d;
            s0_eop_q       <= s0_eop_d;  s0_pend_q <= s0_pend_d;
            s1_word_q      <= s1_word_d; s1_vld_q <= s1_vld_d; s1_mask_q <= s1_mask_d;
            s1_eop_q       <= s1_eop_d;  s1_pend_q <= s1_pend_d; s1_bad_q <= s1_bad_d;
            out_data_q     <= out_data_d;
            out_data_wr_q  <= out_data_wr_d;
            out_valid_q    <= out_valid_d;
            out_valid_wr_q <= out_valid_wr_d;
            fwd_cnt_q      <= fwd_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

endmodule
